// File: rtl/red_pitaya_quotient_sat.sv
// Purpose  : sequential saturating fixed-point divider, (dividend << SHIFT) / divisor -> BITS_OUT signed.
// Latency  : valid_o pulses BITS_IN1+SHIFT+2 cycles after the accept edge (26 at defaults).
// Backpres.: single request in flight; start_i is accepted only while ready_o=1, otherwise ignored.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               request, accepted when ready_o=1 (operands sampled on that edge)
//   dividend_i/divisor_i  signed operands
//   ready_o               idle, can accept start_i
//   valid_o               one-cycle pulse when quotient_o/overflow_o/div_zero_o update
//   quotient_o            signed saturated quotient, held until the next valid_o
//   overflow_o            result saturated (includes divide-by-zero)
//   div_zero_o            divisor was zero
//
// Optional build macro RED_PITAYA_QUOTIENT_ROUND_EN: round half away from zero instead of truncating.

module red_pitaya_quotient_sat #(
    parameter int BITS_IN1 = 14,
    parameter int BITS_IN2 = 14,
    parameter int BITS_OUT = 14,
    parameter int SHIFT    = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic signed [BITS_IN1-1:0] dividend_i,
    input  logic signed [BITS_IN2-1:0] divisor_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic signed [BITS_OUT-1:0] quotient_o,
    output logic                       overflow_o,
    output logic                       div_zero_o
);

    localparam int NW = BITS_IN1 + SHIFT;      // numerator / quotient magnitude width
    localparam int CW = $clog2(NW + 1);

    localparam logic [NW:0] POS_LIM = (NW+1)'((2 ** (BITS_OUT-1)) - 1);
    localparam logic [NW:0] NEG_LIM = (NW+1)'(2 ** (BITS_OUT-1));
    localparam logic [BITS_OUT-1:0] Q_MAX = {1'b0, {(BITS_OUT-1){1'b1}}};
    localparam logic [BITS_OUT-1:0] Q_MIN = {1'b1, {(BITS_OUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t              state;
    logic                sgn;        // result negative
    logic                dvd_neg;    // dividend negative (selects divide-by-zero saturation side)
    logic                dzero;
    logic [BITS_IN2-1:0] dmag;
    logic [NW-1:0]       nq;         // numerator bits shift out at the top, quotient bits shift in at the bottom
    logic [BITS_IN2:0]   rem;
    logic [CW-1:0]       cnt;

    // Unsigned magnitudes; BITS wide is enough for the most negative input.
    logic [BITS_IN1-1:0] a_mag;
    logic [BITS_IN2-1:0] b_mag;
    assign a_mag = dividend_i[BITS_IN1-1] ? (~dividend_i + BITS_IN1'(1)) : dividend_i;
    assign b_mag = divisor_i[BITS_IN2-1]  ? (~divisor_i  + BITS_IN2'(1)) : divisor_i;

    // One restoring step: bring down the next numerator bit, subtract if it fits.
    logic [BITS_IN2:0] trial;
    logic              fits;
    logic [BITS_IN2:0] rem_nxt;
    assign trial   = {rem[BITS_IN2-1:0], nq[NW-1]};
    assign fits    = (trial >= {1'b0, dmag});
    assign rem_nxt = fits ? (trial - {1'b0, dmag}) : trial;

    // Final magnitude, widened by one bit so a rounding increment cannot wrap.
    logic [NW:0] qmag;
`ifdef RED_PITAYA_QUOTIENT_ROUND_EN
    logic [BITS_IN2+1:0] rem2;
    logic                rnd;
    assign rem2 = {rem, 1'b0};
    assign rnd  = (rem2 >= {2'b00, dmag});
    assign qmag = {1'b0, nq} + (NW+1)'(rnd);
`else
    assign qmag = {1'b0, nq};
`endif

    logic [BITS_OUT-1:0] q_res;
    logic                ovf_res;
    always_comb begin
        q_res   = '0;
        ovf_res = 1'b0;
        if (dzero) begin
            q_res   = dvd_neg ? Q_MIN : Q_MAX;
            ovf_res = 1'b1;
        end else if (!sgn) begin
            if (qmag > POS_LIM) begin
                q_res   = Q_MAX;
                ovf_res = 1'b1;
            end else begin
                q_res = qmag[BITS_OUT-1:0];
            end
        end else begin
            // A magnitude of exactly 2^(BITS_OUT-1) negates to the minimum code without overflow.
            if (qmag > NEG_LIM) begin
                q_res   = Q_MIN;
                ovf_res = 1'b1;
            end else begin
                q_res = -qmag[BITS_OUT-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            quotient_o <= '0;
            overflow_o <= 1'b0;
            div_zero_o <= 1'b0;
            sgn        <= 1'b0;
            dvd_neg    <= 1'b0;
            dzero      <= 1'b0;
            dmag       <= '0;
            nq         <= '0;
            rem        <= '0;
            cnt        <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sgn     <= dividend_i[BITS_IN1-1] ^ divisor_i[BITS_IN2-1];
                        dvd_neg <= dividend_i[BITS_IN1-1];
                        dzero   <= (divisor_i == '0);
                        dmag    <= b_mag;
                        nq      <= {a_mag, {SHIFT{1'b0}}};
                        rem     <= '0;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    // NW iterations, then one cycle recognising completion.
                    if (cnt == CW'(NW)) begin
                        state <= DONE;
                    end else begin
                        rem <= rem_nxt;
                        nq  <= {nq[NW-2:0], fits};
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    quotient_o <= q_res;
                    overflow_o <= ovf_res;
                    div_zero_o <= dzero;
                    valid_o    <= 1'b1;
                    ready_o    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
